// File: rtl/heart_pkg.sv
// heart_pkg: shared widths, colour constants and arithmetic helpers for the
// heart renderer slice (heart_renderer, circle_hit_pipe, heart_renderer_if).
//   COORD_W     width of heart geometry (centre x/y, radius)
//   PIX_W       width of raster pixel coordinates
//   RGB_W       packed {R4,G4,B4} colour width
//   sq_dist_w() width of dx^2 + dy^2 that cannot overflow
package heart_pkg;

  localparam int COORD_W = 16;
  localparam int PIX_W   = 10;
  localparam int RGB_W   = 12;

  localparam logic [RGB_W-1:0] RGB_BLACK = 12'h000;
  localparam logic [RGB_W-1:0] RGB_RED   = 12'hF00;

  // dx/dy are COORD_W+1 bits signed, each square needs 2*(COORD_W+1) bits and
  // the sum of two squares one more carry bit.
  function automatic int sq_dist_w();
    return 2 * (COORD_W + 1) + 1;
  endfunction

endpackage

// File: rtl/heart_renderer_if.sv
// heart_renderer_if: pixel stream + heart geometry in, composited pixel out.
//   master: VGA timing/background side (drives i_*, observes o_*)
//   slave : heart_renderer (consumes i_*, drives o_*)
//   i_pix_stb, i_x, i_y, i_active, i_frame_start, i_bg_rgb  raster stream
//   i_cx, i_cy, i_r                                         heart geometry
//   i_hit                                                   damage pulse
//   o_valid, o_heart, o_rgb, o_invuln                       composited result
interface heart_renderer_if;

  logic                          i_pix_stb;
  logic [heart_pkg::PIX_W-1:0]   i_x;
  logic [heart_pkg::PIX_W-1:0]   i_y;
  logic                          i_active;
  logic                          i_frame_start;
  logic [heart_pkg::RGB_W-1:0]   i_bg_rgb;
  logic [heart_pkg::COORD_W-1:0] i_cx;
  logic [heart_pkg::COORD_W-1:0] i_cy;
  logic [heart_pkg::COORD_W-1:0] i_r;
  logic                          i_hit;
  logic                          o_valid;
  logic                          o_heart;
  logic [heart_pkg::RGB_W-1:0]   o_rgb;
  logic                          o_invuln;

  modport master (
    output i_pix_stb, i_x, i_y, i_active, i_frame_start, i_bg_rgb,
    output i_cx, i_cy, i_r, i_hit,
    input  o_valid, o_heart, o_rgb, o_invuln
  );

  modport slave (
    input  i_pix_stb, i_x, i_y, i_active, i_frame_start, i_bg_rgb,
    input  i_cx, i_cy, i_r, i_hit,
    output o_valid, o_heart, o_rgb, o_invuln
  );

endinterface

// File: rtl/heart_renderer_circle_hit_pipe.sv
// circle_hit_pipe: 3-stage "is pixel within radius of centre" pipeline.
//   S1 dx/dy, S2 squares, S3 compare. Everything holds while stall_i=1.
//   i_clk, i_rst    clock, synchronous active-high reset
//   stall_i         1 = hold all stages
//   x_i, y_i        pixel coordinate
//   active_i, vis_i, bg_rgb_i  side-band carried alongside the pixel
//   cx_i, cy_i, r_i geometry used by S1 for this pixel
//   inside_o        S3: distance <= r and r != 0
//   active_o, vis_o, bg_rgb_o  side-band aligned with inside_o
module circle_hit_pipe
  import heart_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               stall_i,
  input  logic [PIX_W-1:0]   x_i,
  input  logic [PIX_W-1:0]   y_i,
  input  logic               active_i,
  input  logic               vis_i,
  input  logic [RGB_W-1:0]   bg_rgb_i,
  input  logic [COORD_W-1:0] cx_i,
  input  logic [COORD_W-1:0] cy_i,
  input  logic [COORD_W-1:0] r_i,
  output logic               inside_o,
  output logic               active_o,
  output logic               vis_o,
  output logic [RGB_W-1:0]   bg_rgb_o
);

  localparam int D_W   = COORD_W + 1;
  localparam int SQ_W  = 2 * D_W;
  localparam int R2_W  = 2 * COORD_W;
  localparam int SUM_W = sq_dist_w();

  // S1
  logic signed [D_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [COORD_W-1:0]    r1_q;
  logic                  act1_q, vis1_q;
  logic [RGB_W-1:0]      bg1_q;
  // S2
  logic [SQ_W-1:0]       dx2_q, dx2_d, dy2_q, dy2_d;
  logic [R2_W-1:0]       r2_q, r2_d;
  logic                  rnz2_q, act2_q, vis2_q;
  logic [RGB_W-1:0]      bg2_q;
  // S3
  logic                  inside_q, inside_d, act3_q, vis3_q;
  logic [RGB_W-1:0]      bg3_q;

  logic signed [SQ_W-1:0] dx_ext, dy_ext, dx_sq, dy_sq;
  logic [SUM_W-1:0]       dist_sum;

  // NOTE: every signal written here gets a value on every path; a missed
  // assignment in always_comb would infer a latch.
  always_comb begin
    // Zero-extended pixel minus centre: a centre off-screen to the right or
    // below yields a negative delta, which is what clips the heart correctly.
    dx_d   = D_W'({1'b0, x_i}) - D_W'(cx_i);
    dy_d   = D_W'({1'b0, y_i}) - D_W'(cy_i);
    dx_ext = {{(SQ_W-D_W){dx_q[D_W-1]}}, dx_q};
    dy_ext = {{(SQ_W-D_W){dy_q[D_W-1]}}, dy_q};
    dx_sq  = dx_ext * dx_ext;
    dy_sq  = dy_ext * dy_ext;
    dx2_d  = dx_sq;
    dy2_d  = dy_sq;
    r2_d   = R2_W'(r1_q) * R2_W'(r1_q);
    dist_sum = SUM_W'(dx2_q) + SUM_W'(dy2_q);
    inside_d = rnz2_q && (dist_sum <= SUM_W'(r2_q));
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's value from before the edge.
  // NOTE: there are no memories here, so every register is cleared by the
  // synchronous reset and the pipeline flushes to "inactive, black".
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dx_q     <= '0;
      dy_q     <= '0;
      r1_q     <= '0;
      act1_q   <= 1'b0;
      vis1_q   <= 1'b0;
      bg1_q    <= '0;
      dx2_q    <= '0;
      dy2_q    <= '0;
      r2_q     <= '0;
      rnz2_q   <= 1'b0;
      act2_q   <= 1'b0;
      vis2_q   <= 1'b0;
      bg2_q    <= '0;
      inside_q <= 1'b0;
      act3_q   <= 1'b0;
      vis3_q   <= 1'b0;
      bg3_q    <= '0;
    end else if (!stall_i) begin
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      // Radius travels with its pixel so a frame_start between S1 and S2
      // cannot mix old deltas with a new radius.
      r1_q     <= r_i;
      act1_q   <= active_i;
      vis1_q   <= vis_i;
      bg1_q    <= bg_rgb_i;
      dx2_q    <= dx2_d;
      dy2_q    <= dy2_d;
      r2_q     <= r2_d;
      rnz2_q   <= (r1_q != '0);
      act2_q   <= act1_q;
      vis2_q   <= vis1_q;
      bg2_q    <= bg1_q;
      inside_q <= inside_d;
      act3_q   <= act2_q;
      vis3_q   <= vis2_q;
      bg3_q    <= bg2_q;
    end
  end

  assign inside_o = inside_q;
  assign active_o = act3_q;
  assign vis_o    = vis3_q;
  assign bg_rgb_o = bg3_q;

endmodule

// File: rtl/heart_renderer.sv
// heart_renderer: overlays a circular heart on the VGA pixel stream.
//   Geometry is shadowed at each frame_start so mid-frame updates never tear.
//   Output lags the input by exactly 3 pixel strobes.
//   Optional macro HEART_BLINK_EN: damage blink / invulnerability window
//   started by i_hit; without it i_hit is ignored and o_invuln is 0.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   bus           heart_renderer_if.slave (pixel stream, geometry, hit, result)
// Parameters:
//   HEART_RGB     heart colour {R4,G4,B4}
//   BLINK_FRAMES  frames of invulnerability after a hit
//   BLINK_SHIFT   blink counter bit gating visibility (period 2^(SHIFT+1))
module heart_renderer
  import heart_pkg::*;
#(
  parameter logic [RGB_W-1:0] HEART_RGB    = RGB_RED,
  parameter int               BLINK_FRAMES = 60,
  parameter int               BLINK_SHIFT  = 2
) (
  input logic             i_clk,
  input logic             i_rst,
  heart_renderer_if.slave bus
);

  logic [COORD_W-1:0] sh_cx_q, sh_cx_d, sh_cy_q, sh_cy_d, sh_r_q, sh_r_d;
  logic               vis, invuln;
  logic               p_inside, p_active, p_vis;
  logic [RGB_W-1:0]   p_bg;
  logic               heart;
  logic [RGB_W-1:0]   rgb;

  always_comb begin
    sh_cx_d = sh_cx_q;
    sh_cy_d = sh_cy_q;
    sh_r_d  = sh_r_q;
    if (bus.i_frame_start) begin
      sh_cx_d = bus.i_cx;
      sh_cy_d = bus.i_cy;
      sh_r_d  = bus.i_r;
    end
  end

  // The pipeline reads the registered shadow, so a strobe coinciding with
  // frame_start still renders with the previous frame's geometry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_cx_q <= '0;
      sh_cy_q <= '0;
      sh_r_q  <= '0;
    end else begin
      sh_cx_q <= sh_cx_d;
      sh_cy_q <= sh_cy_d;
      sh_r_q  <= sh_r_d;
    end
  end

`ifdef HEART_BLINK_EN
  localparam int CNT_RAW = $clog2(BLINK_FRAMES + 1);
  localparam int CNT_W   = (CNT_RAW > BLINK_SHIFT) ? CNT_RAW : BLINK_SHIFT + 1;

  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;

  // A hit always restarts the window, even on a frame_start cycle.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    if (bus.i_hit) begin
      blink_cnt_d = CNT_W'(BLINK_FRAMES);
    end else if (bus.i_frame_start && (blink_cnt_q != '0)) begin
      blink_cnt_d = blink_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink_cnt_q <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign invuln = (blink_cnt_q != '0);
  assign vis    = (blink_cnt_q == '0) | ~blink_cnt_q[BLINK_SHIFT];
`else
  logic unused_hit;
  assign unused_hit = bus.i_hit;
  assign invuln     = 1'b0;
  assign vis        = 1'b1;
`endif

  circle_hit_pipe u_pipe (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .stall_i  (~bus.i_pix_stb),
    .x_i      (bus.i_x),
    .y_i      (bus.i_y),
    .active_i (bus.i_active),
    .vis_i    (vis),
    .bg_rgb_i (bus.i_bg_rgb),
    .cx_i     (sh_cx_q),
    .cy_i     (sh_cy_q),
    .r_i      (sh_r_q),
    .inside_o (p_inside),
    .active_o (p_active),
    .vis_o    (p_vis),
    .bg_rgb_o (p_bg)
  );

  always_comb begin
    heart = p_inside & p_active & p_vis;
    rgb   = RGB_BLACK;
    if (p_active) begin
      rgb = heart ? HEART_RGB : p_bg;
    end
  end

  assign bus.o_valid  = p_active;
  assign bus.o_heart  = heart;
  assign bus.o_rgb    = rgb;
  assign bus.o_invuln = invuln;

endmodule

// File: tb/tb_heart_renderer.sv
// tb_heart_renderer: scoreboard bench for heart_renderer. Each strobe pushes
// the modelled output; it is popped once the pixel has crossed the 3 stages.
// Blink scenarios compile when HEART_BLINK_EN is defined.
module tb_heart_renderer;
  import heart_pkg::*;

  localparam int BF = 8;
  localparam int BS = 1;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  heart_renderer_if bus ();

  heart_renderer #(
    .HEART_RGB   (12'hF00),
    .BLINK_FRAMES(BF),
    .BLINK_SHIFT (BS)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic        valid;
    logic        heart;
    logic [11:0] rgb;
  } exp_t;

  typedef struct {
    bit          stb;
    bit          fs;
    bit          hit;
    logic [15:0] cx;
    logic [15:0] cy;
    logic [15:0] r;
    logic [9:0]  x;
    logic [9:0]  y;
    bit          act;
    logic [11:0] bg;
    int          want;  // -1: no fixed expectation for o_heart
  } px_t;

  exp_t        sb[$];
  int          wq[$];
  logic [15:0] m_cx, m_cy, m_r;
  int          m_cnt;
  int          n_cmp = 0;
  int          n_mis = 0;

  function automatic exp_t dut_out();
    return {bus.o_valid, bus.o_heart, bus.o_rgb};
  endfunction

  function automatic px_t mk(bit stb, bit fs, bit hit, int cx, int cy, int r,
                             int x, int y, bit act, int want);
    px_t p;
    p.stb = stb; p.fs = fs; p.hit = hit;
    p.cx = 16'(cx); p.cy = 16'(cy); p.r = 16'(r);
    p.x = 10'(x); p.y = 10'(y); p.act = act; p.bg = 12'h00F; p.want = want;
    return p;
  endfunction

  function automatic exp_t model(px_t p);
    exp_t   e;
    longint dx, dy, rr;
    bit     vis;
    vis = 1'b1;
`ifdef HEART_BLINK_EN
    vis = (m_cnt == 0) || (m_cnt[BS] == 1'b0);
`endif
    dx = longint'(p.x) - longint'(m_cx);
    dy = longint'(p.y) - longint'(m_cy);
    rr = longint'(m_r) * longint'(m_r);
    e.valid = p.act;
    e.heart = p.act && vis && (m_r != 0) && (dx * dx + dy * dy <= rr);
    e.rgb   = !p.act ? 12'h000 : (e.heart ? 12'hF00 : p.bg);
    return e;
  endfunction

  // One clock cycle of stimulus; returns the expectation for the pixel that
  // has just reached the output, if this cycle was a strobe.
  task automatic drive(input px_t p, output exp_t e, output int w, output bit got);
    bus.i_cx = p.cx; bus.i_cy = p.cy; bus.i_r = p.r;
    bus.i_x = p.x; bus.i_y = p.y; bus.i_active = p.act; bus.i_bg_rgb = p.bg;
    bus.i_pix_stb = p.stb; bus.i_frame_start = p.fs; bus.i_hit = p.hit;
    got = 1'b0; e = '0; w = -1;
    if (p.stb) begin
      sb.push_back(model(p));
      wq.push_back(p.want);
    end
    if (p.fs) begin
      m_cx = p.cx; m_cy = p.cy; m_r = p.r;
    end
`ifdef HEART_BLINK_EN
    if (p.hit) m_cnt = BF;
    else if (p.fs && m_cnt != 0) m_cnt--;
`endif
    @(posedge i_clk);
    #1;
    if (p.stb && sb.size() >= 3) begin
      e = sb.pop_front();
      w = wq.pop_front();
      got = 1'b1;
    end
    bus.i_pix_stb = 1'b0; bus.i_frame_start = 1'b0; bus.i_hit = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) begin
      @(posedge i_clk);
      #1;
    end
    i_rst = 1'b0;
    bus.i_pix_stb = 1'b0; bus.i_frame_start = 1'b0; bus.i_hit = 1'b0;
    m_cx = '0; m_cy = '0; m_r = '0; m_cnt = 0;
    sb.delete(); wq.delete();
    // The flushed S1/S2 registers surface as two inactive pixels.
    repeat (2) begin
      sb.push_back('0);
      wq.push_back(-1);
    end
  endtask

  task automatic test_reset();
    exp_t e; int w; bit got;
    px_t  tab[3];
    // Junk on every input during reset must not leak into any register.
    bus.i_cx = 16'd320; bus.i_cy = 16'd240; bus.i_r = 16'd5;
    bus.i_x = 10'd320; bus.i_y = 10'd240; bus.i_active = 1'b1;
    bus.i_bg_rgb = 12'h0F0; bus.i_pix_stb = 1'b1; bus.i_frame_start = 1'b1;
    bus.i_hit = 1'b1;
    i_rst = 1'b1;
    repeat (3) begin
      @(posedge i_clk);
      #1;
    end
    n_cmp++;
    if (dut_out() !== 14'h0 || bus.o_invuln !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_out: got out=%h invuln=%b, need 0/0", dut_out(), bus.o_invuln);
    end
    do_reset();
    // Geometry inputs present but no frame_start yet: shadow radius is 0.
    for (int i = 0; i < 3; i++) tab[i] = mk(1, 0, 0, 320, 240, 5, 320, 240, 1, 0);
    foreach (tab[i]) begin
      drive(tab[i], e, w, got);
      if (got) begin
        n_cmp++;
        if (dut_out() !== e) begin
          n_mis++;
          $display("FAIL reset_flush[%0d]: got %h need %h", i, dut_out(), e);
        end
        if (w >= 0) begin
          n_cmp++;
          if (bus.o_heart !== w[0]) begin
            n_mis++;
            $display("FAIL reset_nogeom[%0d]: heart %b need %0d", i, bus.o_heart, w);
          end
        end
      end
    end
  endtask

  task automatic test_basic();
    exp_t e; int w; bit got;
    px_t  tab[8];
    tab[0] = mk(0, 1, 0, 320, 240, 5, 0, 0, 0, -1);
    tab[1] = mk(1, 0, 0, 320, 240, 5, 320, 240, 1, 1);
    tab[2] = mk(1, 0, 0, 320, 240, 5, 325, 240, 1, 1);
    tab[3] = mk(1, 0, 0, 320, 240, 5, 326, 240, 1, 0);
    tab[4] = mk(1, 0, 0, 320, 240, 5, 323, 244, 1, 1);
    tab[5] = mk(1, 0, 0, 320, 240, 5, 324, 244, 1, 0);
    tab[6] = mk(1, 0, 0, 320, 240, 5, 0, 0, 0, 0);
    tab[7] = mk(1, 0, 0, 320, 240, 5, 0, 0, 0, 0);
    foreach (tab[i]) begin
      drive(tab[i], e, w, got);
      if (got) begin
        n_cmp++;
        if (dut_out() !== e) begin
          n_mis++;
          $display("FAIL basic[%0d]: got %h need %h", i, dut_out(), e);
        end
        if (w >= 0) begin
          n_cmp++;
          if (bus.o_heart !== w[0] || bus.o_rgb !== (w[0] ? 12'hF00 : 12'h00F) && bus.o_valid) begin
            n_mis++;
            $display("FAIL basic_fixed[%0d]: heart %b rgb %h need heart %0d", i, bus.o_heart, bus.o_rgb, w);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    exp_t e, held; int w; bit got;
    px_t  tab[7];
    px_t  idle;
    held = '0;
    tab[0] = mk(1, 0, 0, 320, 240, 5, 320, 240, 1, 1);
    tab[1] = mk(1, 0, 0, 320, 240, 5, 330, 240, 1, 0);
    tab[2] = mk(1, 0, 0, 320, 240, 5, 320, 245, 1, 1);
    tab[3] = mk(1, 0, 0, 320, 240, 5, 316, 236, 1, 0);
    tab[4] = mk(1, 0, 0, 320, 240, 5, 317, 237, 1, 1);
    tab[5] = mk(1, 0, 0, 320, 240, 5, 0, 0, 0, 0);
    tab[6] = mk(1, 0, 0, 320, 240, 5, 0, 0, 0, 0);
    idle   = mk(0, 0, 0, 320, 240, 5, 500, 500, 1, -1);
    foreach (tab[i]) begin
      drive(tab[i], e, w, got);
      if (got) begin
        held = e;
        n_cmp++;
        if (dut_out() !== e) begin
          n_mis++;
          $display("FAIL stall_seq[%0d]: got %h need %h", i, dut_out(), e);
        end
        if (w >= 0) begin
          n_cmp++;
          if (bus.o_heart !== w[0]) begin
            n_mis++;
            $display("FAIL stall_fixed[%0d]: heart %b need %0d", i, bus.o_heart, w);
          end
        end
      end
      if (i == 2) begin
        for (int k = 0; k < 4; k++) begin
          drive(idle, e, w, got);
          n_cmp++;
          if (dut_out() !== held) begin
            n_mis++;
            $display("FAIL stall_hold[%0d]: got %h need %h", k, dut_out(), held);
          end
        end
      end
    end
  endtask

  task automatic test_shadow();
    exp_t e; int w; bit got;
    px_t  tab[10];
    // i_cx moves to 100 mid-frame: shadow still 320.
    tab[0] = mk(1, 0, 0, 100, 240, 5, 320, 240, 1, 1);
    tab[1] = mk(0, 1, 0, 100, 240, 5, 0, 0, 0, -1);
    tab[2] = mk(1, 0, 0, 100, 240, 5, 320, 240, 1, 0);
    tab[3] = mk(1, 0, 0, 100, 240, 5, 100, 240, 1, 1);
    // frame_start on a strobe: this pixel still sees cx=100, the next one 320.
    tab[4] = mk(1, 1, 0, 320, 240, 5, 100, 240, 1, 1);
    tab[5] = mk(1, 0, 0, 320, 240, 5, 100, 240, 1, 0);
    tab[6] = mk(1, 0, 0, 320, 240, 5, 320, 240, 1, 1);
    tab[7] = mk(1, 0, 0, 320, 240, 5, 0, 0, 0, 0);
    tab[8] = mk(1, 0, 0, 320, 240, 5, 0, 0, 0, 0);
    tab[9] = mk(1, 0, 0, 320, 240, 5, 0, 0, 0, 0);
    foreach (tab[i]) begin
      drive(tab[i], e, w, got);
      if (got) begin
        n_cmp++;
        if (dut_out() !== e) begin
          n_mis++;
          $display("FAIL shadow[%0d]: got %h need %h", i, dut_out(), e);
        end
        if (w >= 0) begin
          n_cmp++;
          if (bus.o_heart !== w[0]) begin
            n_mis++;
            $display("FAIL shadow_fixed[%0d]: heart %b need %0d", i, bus.o_heart, w);
          end
        end
      end
    end
  endtask

  task automatic test_boundary();
    exp_t e; int w; bit got;
    px_t  tab[14];
    tab[0]  = mk(0, 1, 0, 10, 10, 0, 0, 0, 0, -1);
    tab[1]  = mk(1, 0, 0, 10, 10, 0, 10, 10, 1, 0);
    tab[2]  = mk(0, 1, 0, 0, 0, 5, 0, 0, 0, -1);
    tab[3]  = mk(1, 0, 0, 0, 0, 5, 0, 0, 1, 1);
    tab[4]  = mk(1, 0, 0, 0, 0, 5, 3, 4, 1, 1);
    tab[5]  = mk(1, 0, 0, 0, 0, 5, 4, 4, 1, 0);
    tab[6]  = mk(1, 0, 0, 0, 0, 5, 5, 0, 1, 1);
    // Centre beyond the right edge of the raster.
    tab[7]  = mk(0, 1, 0, 1030, 240, 10, 0, 0, 0, -1);
    tab[8]  = mk(1, 0, 0, 1030, 240, 10, 1023, 240, 1, 1);
    tab[9]  = mk(1, 0, 0, 1030, 240, 10, 1019, 240, 1, 0);
    tab[10] = mk(1, 0, 0, 1030, 240, 10, 1023, 247, 1, 1);
    tab[11] = mk(1, 0, 0, 1030, 240, 10, 0, 0, 0, 0);
    tab[12] = mk(1, 0, 0, 1030, 240, 10, 0, 0, 0, 0);
    tab[13] = mk(1, 0, 0, 1030, 240, 10, 0, 0, 0, 0);
    foreach (tab[i]) begin
      drive(tab[i], e, w, got);
      if (got) begin
        n_cmp++;
        if (dut_out() !== e) begin
          n_mis++;
          $display("FAIL boundary[%0d]: got %h need %h", i, dut_out(), e);
        end
        if (w >= 0) begin
          n_cmp++;
          if (bus.o_heart !== w[0]) begin
            n_mis++;
            $display("FAIL boundary_fixed[%0d]: heart %b need %0d", i, bus.o_heart, w);
          end
        end
      end
    end
  endtask

  task automatic test_inactive();
    exp_t e; int w; bit got;
    px_t  tab[4];
    tab[0] = mk(0, 1, 0, 320, 240, 5, 0, 0, 0, -1);
    tab[1] = mk(1, 0, 0, 320, 240, 5, 320, 240, 0, 0);
    tab[2] = mk(1, 0, 0, 320, 240, 5, 321, 240, 1, 1);
    tab[3] = mk(1, 0, 0, 320, 240, 5, 0, 0, 0, 0);
    foreach (tab[i]) begin
      drive(tab[i], e, w, got);
      if (got) begin
        n_cmp++;
        if (dut_out() !== e) begin
          n_mis++;
          $display("FAIL inactive[%0d]: got %h need %h", i, dut_out(), e);
        end
        if (i == 3) begin
          n_cmp++;
          if (bus.o_valid !== 1'b0 || bus.o_heart !== 1'b0 || bus.o_rgb !== 12'h000) begin
            n_mis++;
            $display("FAIL inactive_black: got %h need 0000", dut_out());
          end
        end
      end
    end
  endtask

`ifdef HEART_BLINK_EN
  task automatic test_blink();
    exp_t e; int w; bit got;
    int   vis_tab[8] = '{1, 0, 0, 1, 1, 0, 0, 1};
    drive(mk(0, 1, 0, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    drive(mk(0, 0, 1, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    for (int f = 0; f < 8; f++) begin
      n_cmp++;
      if (bus.o_invuln !== 1'b1) begin
        n_mis++;
        $display("FAIL blink_invuln[%0d]: got %b need 1", f, bus.o_invuln);
      end
      drive(mk(1, 0, 0, 320, 240, 5, 320, 240, 1, vis_tab[f]), e, w, got);
      drive(mk(1, 0, 0, 320, 240, 5, 0, 0, 0, -1), e, w, got);
      drive(mk(1, 0, 0, 320, 240, 5, 0, 0, 0, -1), e, w, got);
      n_cmp++;
      if (dut_out() !== e || bus.o_heart !== w[0]) begin
        n_mis++;
        $display("FAIL blink_vis[%0d]: got %h need %h (heart %0d)", f, dut_out(), e, w);
      end
      drive(mk(0, 1, 0, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    end
    n_cmp++;
    if (bus.o_invuln !== 1'b0 || m_cnt != 0) begin
      n_mis++;
      $display("FAIL blink_end: got %b need 0", bus.o_invuln);
    end
    // Second hit at cnt=3 restarts the window at 8.
    drive(mk(0, 0, 1, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    repeat (5) drive(mk(0, 1, 0, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    drive(mk(0, 0, 1, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    repeat (7) drive(mk(0, 1, 0, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    n_cmp++;
    if (bus.o_invuln !== 1'b1) begin
      n_mis++;
      $display("FAIL blink_reload: got %b need 1", bus.o_invuln);
    end
    drive(mk(0, 1, 0, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    n_cmp++;
    if (bus.o_invuln !== 1'b0) begin
      n_mis++;
      $display("FAIL blink_reload_end: got %b need 0", bus.o_invuln);
    end
    // Hit and frame_start together: reload wins.
    drive(mk(0, 0, 1, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    drive(mk(0, 1, 0, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    drive(mk(0, 1, 1, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    repeat (7) drive(mk(0, 1, 0, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    n_cmp++;
    if (bus.o_invuln !== 1'b1) begin
      n_mis++;
      $display("FAIL blink_hit_fs: got %b need 1", bus.o_invuln);
    end
    // Reset inside the window.
    drive(mk(0, 0, 1, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    n_cmp++;
    if (bus.o_invuln !== 1'b0 || dut_out() !== 14'h0) begin
      n_mis++;
      $display("FAIL blink_reset: invuln %b out %h need 0/0", bus.o_invuln, dut_out());
    end
    do_reset();
  endtask
`else
  task automatic test_hit_ignored();
    exp_t e; int w; bit got;
    drive(mk(0, 1, 0, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    drive(mk(0, 0, 1, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    for (int f = 0; f < 4; f++) begin
      n_cmp++;
      if (bus.o_invuln !== 1'b0) begin
        n_mis++;
        $display("FAIL hit_invuln[%0d]: got %b need 0", f, bus.o_invuln);
      end
      drive(mk(1, 0, 0, 320, 240, 5, 320, 240, 1, 1), e, w, got);
      drive(mk(1, 0, 0, 320, 240, 5, 0, 0, 0, -1), e, w, got);
      drive(mk(1, 0, 0, 320, 240, 5, 0, 0, 0, -1), e, w, got);
      n_cmp++;
      if (dut_out() !== e || bus.o_heart !== 1'b1) begin
        n_mis++;
        $display("FAIL hit_vis[%0d]: got %h need %h", f, dut_out(), e);
      end
      drive(mk(0, 1, 0, 320, 240, 5, 0, 0, 0, -1), e, w, got);
    end
  endtask
`endif

  initial begin
    bus.i_pix_stb = 1'b0; bus.i_frame_start = 1'b0; bus.i_hit = 1'b0;
    bus.i_x = '0; bus.i_y = '0; bus.i_active = 1'b0; bus.i_bg_rgb = '0;
    bus.i_cx = '0; bus.i_cy = '0; bus.i_r = '0;
    m_cx = '0; m_cy = '0; m_r = '0; m_cnt = 0;
    test_reset();
    test_basic();
    test_stall();
    test_shadow();
    test_boundary();
    test_inactive();
`ifdef HEART_BLINK_EN
    test_blink();
`else
    test_hit_ignored();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
